// File: rtl/instr_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs : shared definitions for the fetch stage and its neighbours.
//   - opcode constants (halt, jump, register jump, jump-and-link, branch)
//   - pc_src encodings used by the control unit to pick the next PC
//   - fetch FSM state encoding
//   - pc_wrap(): folds an address into instruction memory, word aligned
// ---------------------------------------------------------------------------
package cpu_defs;

   localparam logic [5:0] HALT_OP = 6'b111111;
   localparam logic [5:0] J_OP    = 6'b111000;
   localparam logic [5:0] JR_OP   = 6'b111001;
   localparam logic [5:0] JAL_OP  = 6'b111010;
   localparam logic [5:0] BEQ_OP  = 6'b110100;

   localparam logic [1:0] PCSRC_SEQ = 2'b00;
   localparam logic [1:0] PCSRC_BR  = 2'b01;
   localparam logic [1:0] PCSRC_J   = 2'b10;
   localparam logic [1:0] PCSRC_REG = 2'b11;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

   // mem_bytes is a power of two, so modulo is a mask; low two bits are
   // cleared because every fetch address is a word address.
   function automatic logic [31:0] pc_wrap(input logic [31:0] addr,
                                           input int unsigned mem_bytes);
      return addr & 32'(mem_bytes - 1) & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if : instruction memory read port.
//   InsAddr  byte address driven by the fetch unit (equals PC)
//   InsData  32-bit word returned combinationally by the memory
// modport master : fetch unit side
// modport slave  : instruction memory side
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if;
   logic [31:0] InsAddr;
   logic [31:0] InsData;

   modport master (output InsAddr, input InsData);
   modport slave  (input InsAddr, output InsData);
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// ---------------------------------------------------------------------------
// next_pc_calc : combinational next-PC selection.
//   pc4          (PC+4) already folded into memory
//   ir           current instruction (imm16 / target26 fields)
//   rs_data      register target for jr
//   pc_src       00 seq, 01 branch, 10 jump, 11 register
//   branch_taken only looked at for pc_src = 01
//   next_pc      selected target, folded into memory and word aligned
// ---------------------------------------------------------------------------
module next_pc_calc
   import cpu_defs::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic [31:0] pc4,
   input  logic [31:0] ir,
   input  logic [31:0] rs_data,
   input  logic [1:0]  pc_src,
   input  logic        branch_taken,
   output logic [31:0] next_pc
);

   logic [31:0] br_off;
   logic [31:0] target;
   logic        unused_op;

   // word offset: sign-extended imm16 shifted left by two
   assign br_off = {{14{ir[15]}}, ir[15:0], 2'b00};

   always_comb begin
      target = pc4;
      case (pc_src)
         PCSRC_SEQ: target = pc4;
         PCSRC_BR:  target = branch_taken ? (pc4 + br_off) : pc4;
         PCSRC_J:   target = {pc4[31:28], ir[25:0], 2'b00};
         PCSRC_REG: target = rs_data;
      endcase
   end

   // misaligned or out-of-range targets are folded silently
   assign next_pc = pc_wrap(target, MEM_BYTES);

   // opcode field is decoded by the control unit, not here
   assign unused_op = ^ir[31:26];

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit : fetch stage of the multi-cycle CPU.
//   CLK, Reset    clock, asynchronous active-high reset
//   pc_write      one-cycle commit pulse from control (honoured in EXEC only)
//   pc_src        next-PC select, see next_pc_calc
//   branch_taken  branch condition
//   rs_data       jr target
//   imem          instruction memory read port (InsAddr = PC, InsData)
//   IR            latched instruction
//   PC, PC4       current PC and (PC+4) folded into memory (PC4 is comb)
//   ir_valid      IR holds the instruction at PC
//   halted        halt opcode fetched, sticky until reset
//   instr_count   instructions latched since reset
// FSM: FETCH (1 cycle, latch IR) -> EXEC (wait for pc_write) -> FETCH,
//      or FETCH -> HALT when the fetched word carries the halt opcode.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned MEM_BYTES = 1024,
   parameter logic [5:0]  HALT_OP   = cpu_defs::HALT_OP
) (
   input  logic                      CLK,
   input  logic                      Reset,
   input  logic                      pc_write,
   input  logic [1:0]                pc_src,
   input  logic                      branch_taken,
   input  logic [31:0]               rs_data,
   instr_fetch_unit_if.master        imem,
   output logic [31:0]               IR,
   output logic [31:0]               PC,
   output logic [31:0]               PC4,
   output logic                      ir_valid,
   output logic                      halted,
   output logic [31:0]               instr_count
);

   import cpu_defs::*;

   fetch_state_t state, state_nxt;
   logic         load_ir;
   logic         commit_pc;
   logic         is_halt;
   logic [31:0]  next_pc;

   assign imem.InsAddr = PC;
   assign PC4          = pc_wrap(PC + 32'd4, MEM_BYTES);
   assign is_halt      = (imem.InsData[31:26] == HALT_OP);

   next_pc_calc #(.MEM_BYTES(MEM_BYTES)) u_next_pc (
      .pc4          (PC4),
      .ir           (IR),
      .rs_data      (rs_data),
      .pc_src       (pc_src),
      .branch_taken (branch_taken),
      .next_pc      (next_pc)
   );

   // state register
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) state <= FETCH;
      else       state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:   state_nxt = is_halt ? HALT : EXEC;
         EXEC:    state_nxt = pc_write ? FETCH : EXEC;
         HALT:    state_nxt = HALT;
         default: state_nxt = FETCH;
      endcase
   end

   // state decode: pc_write only matters in EXEC, so pulses seen in FETCH
   // or HALT never reach the PC
   always_comb begin
      load_ir   = 1'b0;
      commit_pc = 1'b0;
      case (state)
         FETCH:   load_ir   = 1'b1;
         EXEC:    commit_pc = pc_write;
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         PC          <= pc_wrap(RESET_PC, MEM_BYTES);
         IR          <= '0;
         ir_valid    <= 1'b0;
         halted      <= 1'b0;
         instr_count <= '0;
      end else begin
         if (load_ir) begin
            IR          <= imem.InsData;
            ir_valid    <= 1'b1;
            instr_count <= instr_count + 32'd1;
            if (is_halt) halted <= 1'b1;
         end
         if (commit_pc) begin
            PC       <= next_pc;
            ir_valid <= 1'b0;
         end
      end
   end

endmodule
